instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 222 ++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Bundles the program-load handshake, encode-request fields and instruction-memory
// write port of instr_encoder.
interface instr_encoder_if;
  logic        start;
  logic [7:0]  base_addr;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cls;
  logic [4:0]  req_code;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic        req_last;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        done;
  logic        err;
  logic [8:0]  count;

  modport master (
    output start, base_addr, req_valid, req_cls, req_code, req_rs, req_rt, req_rd,
           req_imm, req_last,
    input  req_ready, imem_we, imem_addr, imem_wdata, done, err, count
  );

  modport slave (
    input  start, base_addr, req_valid, req_cls, req_code, req_rs, req_rt, req_rd,
           req_imm, req_last,
    output req_ready, imem_we, imem_addr, imem_wdata, done, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes ALU-control style requests into MIPS instruction words and writes them
// sequentially into instruction memory starting at a base address.
module instr_encoder (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StEncode,
    StWrite,
    StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic [1:0]  r_cls;
  logic [4:0]  r_code;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [15:0] r_imm;
  logic        r_last;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_ovf;
  logic [8:0]  r_count;

  logic        w_legal;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [31:0] w_word;
  logic        w_write_ok;

  // Opcode / funct lookup on the latched request.
  always_comb begin
    w_legal = 1'b0;
    w_op    = 6'b000000;
    w_funct = 6'b000000;
    case (r_cls)
      2'b00: begin
        w_legal = 1'b1;
        case (r_code)
          5'b00010: w_funct = 6'b100001;
          5'b00110: w_funct = 6'b100011;
          5'b00000: w_funct = 6'b100100;
          5'b00001: w_funct = 6'b100101;
          5'b00111: w_funct = 6'b101010;
          5'b01010: w_funct = 6'b101011;
          5'b00011: w_funct = 6'b011010;
          5'b00100: w_funct = 6'b011000;
          5'b00101: w_funct = 6'b000100;
          5'b01000: w_funct = 6'b000110;
          5'b01001: w_funct = 6'b100110;
          5'b01011: w_funct = 6'b000111;
          5'b10010: w_funct = 6'b100000;
          5'b10011: w_funct = 6'b100010;
          default:  w_legal = 1'b0;
        endcase
      end
      2'b01: begin
        w_legal = 1'b1;
        case (r_code)
          5'b00010: w_op = 6'b001001;
          5'b00000: w_op = 6'b001100;
          5'b00001: w_op = 6'b001101;
          5'b00111: w_op = 6'b001010;
          5'b01010: w_op = 6'b001011;
          5'b01001: w_op = 6'b001110;
          5'b10010: w_op = 6'b001000;
          default:  w_legal = 1'b0;
        endcase
      end
      2'b10: begin
        w_legal = 1'b1;
        case (r_code)
          5'b00110: w_op = 6'b000100;
          5'b01101: w_op = 6'b000101;
          5'b01110: w_op = 6'b000001;
          5'b01111: w_op = 6'b000111;
          5'b10000: w_op = 6'b000110;
          5'b10001: w_op = 6'b010001;
          default:  w_legal = 1'b0;
        endcase
      end
      default: begin
        w_legal = 1'b1;
        case (r_code)
          5'b00000: w_op = 6'b100011;
          5'b00001: w_op = 6'b101011;
          default:  w_legal = 1'b0;
        endcase
      end
    endcase
  end

  always_comb begin
    if (r_cls == 2'b00) begin
      w_word = {6'b000000, r_rs, r_rt, r_rd, 5'b00000, w_funct};
    end else begin
      w_word = {w_op, r_rs, r_rt, r_imm};
    end
  end

  // After an address overflow, legal requests are still consumed but never written.
  assign w_write_ok = w_legal && !r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = StAccept;
        end
      end
      StAccept: begin
        if (bus.req_valid) begin
          w_state_next = StEncode;
        end
      end
      StEncode: begin
        if (w_write_ok) begin
          w_state_next = StWrite;
        end else if (r_last) begin
          w_state_next = StDone;
        end else begin
          w_state_next = StAccept;
        end
      end
      StWrite: begin
        w_state_next = r_last ? StDone : StAccept;
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.req_ready  = (r_state == StAccept);
    bus.imem_we    = (r_state == StWrite);
    bus.done       = (r_state == StDone);
    bus.imem_addr  = r_addr;
    bus.imem_wdata = r_wdata;
    bus.err        = r_err;
    bus.count      = r_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cls   <= 2'b00;
      r_code  <= 5'b00000;
      r_rs    <= 5'b00000;
      r_rt    <= 5'b00000;
      r_rd    <= 5'b00000;
      r_imm   <= 16'h0000;
      r_last  <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 32'h0000_0000;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= 9'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_addr  <= bus.base_addr;
            r_count <= 9'd0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        StAccept: begin
          if (bus.req_valid) begin
            r_cls  <= bus.req_cls;
            r_code <= bus.req_code;
            r_rs   <= bus.req_rs;
            r_rt   <= bus.req_rt;
            r_rd   <= bus.req_rd;
            r_imm  <= bus.req_imm;
            r_last <= bus.req_last;
          end
        end
        StEncode: begin
          if (!w_legal) begin
            r_err <= 1'b1;
          end else if (!r_ovf) begin
            r_wdata <= w_word;
          end
        end
        StWrite: begin
          r_count <= r_count + 9'd1;
          // The last address is written, then the load is flagged instead of wrapping.
          if (r_addr == 8'hFF) begin
            r_err <= 1'b1;
            r_ovf <= 1'b1;
          end else begin
            r_addr <= r_addr + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboarded writes, latency, errors,
// overflow and asynchronous reset during a write.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [8:0]  m_count = 9'd0;
  logic [31:0] m_data = 32'h0;

  localparam logic [12:0] LegalTab [29] = '{
    {2'd0, 5'b00010, 6'b100001}, {2'd0, 5'b00110, 6'b100011}, {2'd0, 5'b00000, 6'b100100},
    {2'd0, 5'b00001, 6'b100101}, {2'd0, 5'b00111, 6'b101010}, {2'd0, 5'b01010, 6'b101011},
    {2'd0, 5'b00011, 6'b011010}, {2'd0, 5'b00100, 6'b011000}, {2'd0, 5'b00101, 6'b000100},
    {2'd0, 5'b01000, 6'b000110}, {2'd0, 5'b01001, 6'b100110}, {2'd0, 5'b01011, 6'b000111},
    {2'd0, 5'b10010, 6'b100000}, {2'd0, 5'b10011, 6'b100010},
    {2'd1, 5'b00010, 6'b001001}, {2'd1, 5'b00000, 6'b001100}, {2'd1, 5'b00001, 6'b001101},
    {2'd1, 5'b00111, 6'b001010}, {2'd1, 5'b01010, 6'b001011}, {2'd1, 5'b01001, 6'b001110},
    {2'd1, 5'b10010, 6'b001000},
    {2'd2, 5'b00110, 6'b000100}, {2'd2, 5'b01101, 6'b000101}, {2'd2, 5'b01110, 6'b000001},
    {2'd2, 5'b01111, 6'b000111}, {2'd2, 5'b10000, 6'b000110}, {2'd2, 5'b10001, 6'b010001},
    {2'd3, 5'b00000, 6'b100011}, {2'd3, 5'b00001, 6'b101011}
  };

  task automatic do_start(input logic [7:0] base);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    @(posedge clk);
    #1 bus.start = 1'b0;
    m_addr  = base;
    m_count = 9'd0;
  endtask

  // Handshake one request; returns at the negedge two cycles after the handshake.
  task automatic send_req(input logic [1:0] cls, input logic [4:0] code, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                          input logic last, input logic exp_wr, input logic [31:0] exp_data);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_wait: got %b want 1", bus.req_ready);
    end
    bus.req_cls  = cls;
    bus.req_code = code;
    bus.req_rs   = rs;
    bus.req_rt   = rt;
    bus.req_rd   = rd;
    bus.req_imm  = imm;
    bus.req_last = last;
    bus.req_valid = 1'b1;
    if (exp_wr) begin
      exp_q.push_back({m_addr, exp_data});
      m_data = exp_data;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL we_early: got %b want 0", bus.imem_we);
    end
    @(negedge clk);
    vectors++;
    if (bus.imem_we !== exp_wr) begin
      miscompares++;
      $display("FAIL we_latency: got %b want %b (cls=%0d code=%b)", bus.imem_we, exp_wr, cls,
               code);
    end
    if (bus.imem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
      end else begin
        got = exp_q.pop_front();
        if (bus.imem_addr !== got.addr || bus.imem_wdata !== got.data) begin
          miscompares++;
          $display("FAIL write: got addr=%h data=%h want addr=%h data=%h", bus.imem_addr,
                   bus.imem_wdata, got.addr, got.data);
        end
      end
    end
    if (exp_wr) begin
      if (m_addr != 8'hFF) m_addr = m_addr + 8'd1;
      m_count = m_count + 9'd1;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.count !== m_count) begin
      miscompares++;
      $display("FAIL done: got done=%b count=%0d want done=1 count=%0d", bus.done, bus.count,
               m_count);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b ready=%b want 0 0", bus.done, bus.req_ready);
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    vectors++;
    if (bus.req_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== 8'h00 ||
        bus.imem_wdata !== 32'h0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.count !== 9'd0) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b we=%b addr=%h data=%h done=%b err=%b cnt=%0d want all 0",
               tag, bus.req_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.done,
               bus.err, bus.count);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_outputs_reset("reset_values");
    reset = 1'b0;
    @(negedge clk);
    check_outputs_reset("idle_after_reset");
  endtask

  task automatic test_basic();
    do_start(8'h10);
    send_req(2'd0, 5'b00010, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1, 1'b1, 32'h0022_1821);
    wait_done();
    vectors++;
    if (bus.imem_addr !== 8'h11 || bus.imem_wdata !== 32'h0022_1821) begin
      miscompares++;
      $display("FAIL basic_hold: got addr=%h data=%h want 11 00221821", bus.imem_addr,
               bus.imem_wdata);
    end
  endtask

  task automatic test_program();
    do_start(8'h40);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = 8'h99;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_addr !== 8'h40 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ignored: got addr=%h ready=%b want 40 1", bus.imem_addr,
               bus.req_ready);
    end
    send_req(2'd1, 5'b00010, 5'd0, 5'd8, 5'd0, 16'h0005, 1'b0, 1'b1, 32'h2408_0005);
    send_req(2'd2, 5'b01101, 5'd8, 5'd0, 5'd0, 16'hFFFE, 1'b1, 1'b1, 32'h1500_FFFE);
    wait_done();
    vectors++;
    if (bus.imem_wdata !== 32'h1500_FFFE) begin
      miscompares++;
      $display("FAIL program_hold: got %h want 1500fffe", bus.imem_wdata);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] bad [4];
    bad[0] = {2'd0, 5'b11111};
    bad[1] = {2'd1, 5'b00110};
    bad[2] = {2'd2, 5'b00000};
    bad[3] = {2'd3, 5'b00010};
    do_start(8'h20);
    for (int i = 0; i < 4; i++) begin
      send_req(bad[i][6:5], bad[i][4:0], 5'd7, 5'd7, 5'd7, 16'h1234, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (bus.err !== 1'b1 || bus.imem_addr !== 8'h20 || bus.count !== 9'd0 ||
          bus.imem_wdata !== m_data) begin
        miscompares++;
        $display("FAIL illegal_%0d: got err=%b addr=%h cnt=%0d data=%h want 1 20 0 %h", i,
                 bus.err, bus.imem_addr, bus.count, bus.imem_wdata, m_data);
      end
    end
    send_req(2'd0, 5'b00110, 5'd4, 5'd5, 5'd6, 16'h0, 1'b1, 1'b1, 32'h0085_3023);
    wait_done();
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b want 1", bus.err);
    end
  endtask

  task automatic test_table();
    logic [12:0] e;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] word;
    do_start(8'h80);
    @(negedge clk);
    vectors++;
    if (bus.err !== 1'b0 || bus.count !== 9'd0 || bus.imem_addr !== 8'h80) begin
      miscompares++;
      $display("FAIL start_clears: got err=%b cnt=%0d addr=%h want 0 0 80", bus.err, bus.count,
               bus.imem_addr);
    end
    for (int i = 0; i < 29; i++) begin
      e   = LegalTab[i];
      rs  = 5'($urandom_range(0, 31));
      rt  = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      imm = 16'($urandom_range(0, 65535));
      word = (e[12:11] == 2'd0) ? {6'b000000, rs, rt, rd, 5'b00000, e[5:0]}
                                : {e[5:0], rs, rt, imm};
      send_req(e[12:11], e[10:6], rs, rt, rd, imm, (i == 28), 1'b1, word);
    end
    wait_done();
  endtask

  task automatic test_overflow();
    do_start(8'hFF);
    send_req(2'd3, 5'b00000, 5'd1, 5'd2, 5'd0, 16'h0010, 1'b0, 1'b1, 32'h8C22_0010);
    @(negedge clk);
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_err: got %b want 1", bus.err);
    end
    send_req(2'd3, 5'b00000, 5'd3, 5'd4, 5'd0, 16'h0020, 1'b1, 1'b0, 32'h0);
    wait_done();
  endtask

  task automatic test_reset_mid_write();
    do_start(8'h30);
    send_req(2'd0, 5'b00010, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1, 32'h0022_1821);
    #2 reset = 1'b1;
    #1 check_outputs_reset("reset_mid_write");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle: got rdy=%b we=%b want 0 0", bus.req_ready,
                 bus.imem_we);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_cls   = 2'd0;
    bus.req_code  = 5'd0;
    bus.req_rs    = 5'd0;
    bus.req_rt    = 5'd0;
    bus.req_rd    = 5'd0;
    bus.req_imm   = 16'h0;
    bus.req_last  = 1'b0;
    test_reset();
    test_basic();
    test_program();
    test_illegal();
    test_table();
    test_overflow();
    test_reset_mid_write();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
